// File: rtl/crypto_issue_ctrl_if.sv
// Issue-stage / coprocessor / writeback signal bundle for crypto_issue_ctrl.
// slave is the controller side; master is the surrounding core/coprocessor side.
interface crypto_issue_ctrl_if #(
  parameter int XLEN = 64,
  parameter int IdW  = 2
);
  logic              instr_valid_i;
  logic              instr_ready_o;
  logic [31:0]       instr_i;
  logic [3*XLEN-1:0] rs_i;
  logic [4:0]        rd_i;

  logic              issue_valid_o;
  logic              issue_ready_i;
  logic [31:0]       issue_instr_o;
  logic [3*XLEN-1:0] issue_rs_o;
  logic [IdW-1:0]    issue_id_o;
  logic              issue_accept_i;
  logic              issue_writeback_i;

  logic              result_valid_i;
  logic              result_ready_o;
  logic [IdW-1:0]    result_id_i;
  logic [XLEN-1:0]   result_data_i;

  logic              wb_valid_o;
  logic [4:0]        wb_rd_o;
  logic [XLEN-1:0]   wb_data_o;

  logic              illegal_o;
  logic              spurious_o;
  logic              flush_i;
  logic [IdW:0]      outstanding_o;

  modport slave (
    input  instr_valid_i, instr_i, rs_i, rd_i,
    output instr_ready_o,
    output issue_valid_o, issue_instr_o, issue_rs_o, issue_id_o,
    input  issue_ready_i, issue_accept_i, issue_writeback_i,
    input  result_valid_i, result_id_i, result_data_i,
    output result_ready_o,
    output wb_valid_o, wb_rd_o, wb_data_o,
    output illegal_o, spurious_o, outstanding_o,
    input  flush_i
  );

  modport master (
    output instr_valid_i, instr_i, rs_i, rd_i,
    input  instr_ready_o,
    input  issue_valid_o, issue_instr_o, issue_rs_o, issue_id_o,
    output issue_ready_i, issue_accept_i, issue_writeback_i,
    output result_valid_i, result_id_i, result_data_i,
    input  result_ready_o,
    input  wb_valid_o, wb_rd_o, wb_data_o,
    input  illegal_o, spurious_o, outstanding_o,
    output flush_i
  );
endinterface

// File: rtl/crypto_issue_ctrl.sv
// Crypto coprocessor issue initiator: registers offloaded instructions, tracks
// result IDs in a small table and routes out-of-order results to writeback.

module crypto_issue_entry (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       flush_i,
  input  logic       set_pend_i,
  input  logic       set_kill_i,
  input  logic       res_hit_i,
  input  logic [4:0] rd_i,
  output logic [1:0] st_o,
  output logic [4:0] rd_o
);
  localparam logic [1:0] FREE = 2'd0, PEND = 2'd1, KILL = 2'd2;

  // Allocation only targets a FREE entry, so it never races a real writeback;
  // a result beats a flush so the writeback is not lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_o <= FREE;
      rd_o <= '0;
    end else if (set_pend_i) begin
      st_o <= PEND;
      rd_o <= rd_i;
    end else if (set_kill_i) begin
      st_o <= KILL;
    end else if (res_hit_i) begin
      st_o <= FREE;
    end else if (flush_i && st_o == PEND) begin
      st_o <= KILL;
    end
  end
endmodule

module crypto_issue_ctrl #(
  parameter int XLEN  = 64,
  parameter int Depth = 4,
  parameter int IdW   = $clog2(Depth)
) (
  input logic                clk_i,
  input logic                rst_i,
  crypto_issue_ctrl_if.slave bus
);
  localparam logic [0:0] S_IDLE = 1'b0, S_ISSUE = 1'b1;
  localparam logic [1:0] FREE = 2'd0, PEND = 2'd1;

  typedef struct packed {
    logic [31:0]       instr;
    logic [3*XLEN-1:0] rs;
    logic [4:0]        rd;
  } req_t;

  logic [0:0]             state_q;
  req_t                   req_q;
  logic [IdW-1:0]         id_q;
  logic [Depth-1:0][1:0]  ent_st;
  logic [Depth-1:0][4:0]  ent_rd;
  logic [Depth-1:0]       avail, set_pend, set_kill, res_hit;
  logic [IdW-1:0]         alloc_id;
  logic                   full, ready, req_fire, issue_fire, res_fire;
  logic [IdW:0]           cnt;
  logic                   illegal_q, spurious_q, wb_valid_q;
  logic [4:0]             wb_rd_q;
  logic [XLEN-1:0]        wb_data_q;

  // The entry held in ISSUE is still FREE in the table but must not be reused.
  always_comb begin
    avail    = '0;
    alloc_id = '0;
    cnt      = '0;
    for (int i = 0; i < Depth; i++)
      avail[i] = ent_st[i] == FREE && !(state_q == S_ISSUE && id_q == IdW'(i));
    for (int i = Depth - 1; i >= 0; i--)
      if (avail[i]) alloc_id = IdW'(i);
    for (int i = 0; i < Depth; i++)
      cnt = cnt + {{IdW{1'b0}}, ent_st[i] == PEND};
  end

  assign full       = ~|avail;
  assign ready      = !rst_i && state_q == S_IDLE && !full && !bus.flush_i;
  assign req_fire   = bus.instr_valid_i && ready;
  assign issue_fire = state_q == S_ISSUE && bus.issue_ready_i;
  assign res_fire   = bus.result_valid_i && !rst_i;

  for (genvar gi = 0; gi < Depth; gi++) begin : g_ent
    assign set_pend[gi] = issue_fire && !bus.flush_i && bus.issue_accept_i &&
                          bus.issue_writeback_i && id_q == IdW'(gi);
    assign set_kill[gi] = issue_fire && bus.flush_i && bus.issue_writeback_i &&
                          id_q == IdW'(gi);
    assign res_hit[gi]  = res_fire && bus.result_id_i == IdW'(gi);

    crypto_issue_entry u_ent (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .flush_i    (bus.flush_i),
      .set_pend_i (set_pend[gi]),
      .set_kill_i (set_kill[gi]),
      .res_hit_i  (res_hit[gi]),
      .rd_i       (req_q.rd),
      .st_o       (ent_st[gi]),
      .rd_o       (ent_rd[gi])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      id_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE:
          if (req_fire) begin
            req_q   <= '{instr: bus.instr_i, rs: bus.rs_i, rd: bus.rd_i};
            id_q    <= alloc_id;
            state_q <= S_ISSUE;
          end
        default:
          if (bus.flush_i || bus.issue_ready_i) state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      illegal_q  <= 1'b0;
      spurious_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      illegal_q  <= issue_fire && !bus.flush_i && !bus.issue_accept_i;
      wb_valid_q <= res_fire && ent_st[bus.result_id_i] == PEND;
      spurious_q <= res_fire && ent_st[bus.result_id_i] == FREE;
      if (res_fire) begin
        wb_rd_q   <= ent_rd[bus.result_id_i];
        wb_data_q <= bus.result_data_i;
      end
    end
  end

  assign bus.instr_ready_o  = ready;
  assign bus.issue_valid_o  = state_q == S_ISSUE;
  assign bus.issue_instr_o  = req_q.instr;
  assign bus.issue_rs_o     = req_q.rs;
  assign bus.issue_id_o     = id_q;
  assign bus.result_ready_o = !rst_i;
  assign bus.wb_valid_o     = wb_valid_q;
  assign bus.wb_rd_o        = wb_rd_q;
  assign bus.wb_data_o      = wb_data_q;
  assign bus.illegal_o      = illegal_q;
  assign bus.spurious_o     = spurious_q;
  assign bus.outstanding_o  = cnt;
endmodule
